// File: rtl/nxt_pkg.sv
// rtl/nxt_pkg.sv - shared piece codes, cell masks, colours and sizes for the next-piece preview
package nxt_pkg;

  localparam int CODE_W  = 5;
  localparam int COUNT_W = 4;

  localparam logic [CODE_W-1:0] CODE_I = 5'h10;
  localparam logic [CODE_W-1:0] CODE_O = 5'h11;
  localparam logic [CODE_W-1:0] CODE_T = 5'h12;
  localparam logic [CODE_W-1:0] CODE_S = 5'h13;
  localparam logic [CODE_W-1:0] CODE_Z = 5'h14;
  localparam logic [CODE_W-1:0] CODE_J = 5'h15;
  localparam logic [CODE_W-1:0] CODE_L = 5'h16;

  // Cell masks over a 4x2 grid, bit index = row*4 + col
  localparam logic [7:0] MASK_I = 8'h0F;
  localparam logic [7:0] MASK_O = 8'h66;
  localparam logic [7:0] MASK_T = 8'h27;
  localparam logic [7:0] MASK_S = 8'h36;
  localparam logic [7:0] MASK_Z = 8'h63;
  localparam logic [7:0] MASK_J = 8'h47;
  localparam logic [7:0] MASK_L = 8'h17;

  typedef enum logic [1:0] {
    SHADE_LIGHT  = 2'd0,
    SHADE_DARK   = 2'd1,
    SHADE_NORMAL = 2'd2
  } shade_e;

  function automatic logic [7:0] piece_mask(input logic [CODE_W-1:0] code);
    logic [7:0] m;
    case (code)
      CODE_I:  m = MASK_I;
      CODE_O:  m = MASK_O;
      CODE_T:  m = MASK_T;
      CODE_S:  m = MASK_S;
      CODE_Z:  m = MASK_Z;
      CODE_J:  m = MASK_J;
      CODE_L:  m = MASK_L;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Colour trio packed as {light, dark, normal}; unknown codes fall back to red
  function automatic logic [11:0] piece_colour(input logic [CODE_W-1:0] code, input shade_e shade);
    logic [35:0] trio;
    logic [11:0] c;
    case (code)
      CODE_O:  trio = {12'hFF8, 12'hBB6, 12'hFF0};
      CODE_T:  trio = {12'hE8E, 12'h808, 12'hF0F};
      CODE_S:  trio = {12'h9F9, 12'h080, 12'h0F0};
      CODE_Z:  trio = {12'h0BF, 12'h008, 12'h00F};
      CODE_J:  trio = {12'hCFF, 12'h0CF, 12'h0FF};
      CODE_L:  trio = {12'hFC8, 12'h840, 12'hF80};
      default: trio = {12'hFAB, 12'h800, 12'hF00};
    endcase
    case (shade)
      SHADE_LIGHT: c = trio[35:24];
      SHADE_DARK:  c = trio[23:12];
      default:     c = trio[11:0];
    endcase
    return c;
  endfunction

endpackage

// File: rtl/piece_fifo.sv
// rtl/piece_fifo.sv - shift-style FIFO of piece codes, slot 0 is always the head
module piece_fifo
  import nxt_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      push_valid_i,
  input  logic [CODE_W-1:0]         push_code_i,
  output logic                      push_ready_o,
  input  logic                      pop_i,
  output logic [CODE_W-1:0]         head_code_o,
  output logic                      head_valid_o,
  output logic [COUNT_W-1:0]        count_o,
  output logic [DEPTH*CODE_W-1:0]   entries_o
);

  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

  logic [DEPTH*CODE_W-1:0] slots_q, slots_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic [COUNT_W-1:0]      wr_idx;
  logic                    pop_eff;
  logic                    push_acc;

  // A pop on an empty queue is dropped; a pop frees a slot for a same-cycle push even when full
  assign pop_eff      = pop_i && (count_q != '0);
  assign push_ready_o = rst && ((count_q < DEPTH_C) || pop_eff);
  assign push_acc     = push_valid_i && push_ready_o;
  assign wr_idx       = count_q - COUNT_W'(pop_eff);

  // Next slot contents: shift toward the head on pop (zero-filling the tail), then append
  always_comb begin
    slots_d = slots_q;
    if (pop_eff) begin
      slots_d = slots_q >> CODE_W;
    end
    if (push_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == COUNT_W'(i)) begin
          slots_d[i*CODE_W +: CODE_W] = push_code_i;
        end
      end
    end
    count_d = count_q + COUNT_W'(push_acc) - COUNT_W'(pop_eff);
  end

  // Queue state registers
  always_ff @(posedge pclk) begin
    if (!rst) begin
      slots_q <= '0;
      count_q <= '0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
    end
  end

  // Vacated slots are zeroed, so slot 0 reads 0 whenever the queue is empty
  assign head_code_o  = slots_q[CODE_W-1:0];
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;
  assign entries_o    = slots_q;

endmodule

// File: rtl/draw_nxt_queue.sv
// rtl/draw_nxt_queue.sv - next-piece queue with a frame-stable preview overlay on the video stream
module draw_nxt_queue
  import nxt_pkg::*;
#(
  parameter int NUM_SLOTS  = 3,
  parameter int SIZE       = 35,
  parameter int BEVEL      = 3,
  parameter int X_ORIGIN   = 201,
  parameter int Y_ORIGIN   = 10,
  parameter int SLOT_PITCH = 105
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [10:0]        hcount_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic [10:0]        vcount_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic [11:0]        rgb_in,
  input  logic               push_valid,
  input  logic [4:0]         push_code,
  output logic               push_ready,
  input  logic               pop,
  output logic [4:0]         head_code,
  output logic               head_valid,
  output logic [3:0]         count,
  output logic [10:0]        hcount_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic [10:0]        vcount_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic [11:0]        rgb_out
);

  localparam int OFF_W = $clog2(SIZE);

  logic [NUM_SLOTS*CODE_W-1:0] fifo_entries;
  logic [NUM_SLOTS*CODE_W-1:0] shadow_codes_q;
  logic [COUNT_W-1:0]          shadow_count_q;
  logic                        vblnk_prev_q;
  logic                        vblnk_rise;

  piece_fifo #(
    .DEPTH(NUM_SLOTS)
  ) u_fifo (
    .pclk         (pclk),
    .rst          (rst),
    .push_valid_i (push_valid),
    .push_code_i  (push_code),
    .push_ready_o (push_ready),
    .pop_i        (pop),
    .head_code_o  (head_code),
    .head_valid_o (head_valid),
    .count_o      (count),
    .entries_o    (fifo_entries)
  );

  assign vblnk_rise = vblnk_in && !vblnk_prev_q;

  // Snapshot the queue only at the start of vertical blanking so a frame never tears
  always_ff @(posedge pclk) begin
    if (!rst) begin
      vblnk_prev_q   <= 1'b0;
      shadow_codes_q <= '0;
      shadow_count_q <= '0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (vblnk_rise) begin
        shadow_codes_q <= fifo_entries;
        shadow_count_q <= count;
      end
    end
  end

  logic [31:0]        px, py, used;
  logic               occ_d;
  logic [CODE_W-1:0]  code_d;
  logic [OFF_W-1:0]   dx_d, dy_d;

  // Stage 1 decode: find the slot/cell under the pixel with constant-bound comparators
  always_comb begin
    px     = 32'(hcount_in);
    py     = 32'(vcount_in);
    used   = 32'(shadow_count_q);
    occ_d  = 1'b0;
    code_d = '0;
    dx_d   = '0;
    dy_d   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 4; c++) begin
          if ((k < used) &&
              (py >= 32'(Y_ORIGIN + k*SLOT_PITCH + r*SIZE)) &&
              (py <  32'(Y_ORIGIN + k*SLOT_PITCH + (r+1)*SIZE)) &&
              (px >= 32'(X_ORIGIN + c*SIZE)) &&
              (px <  32'(X_ORIGIN + (c+1)*SIZE))) begin
            occ_d  = |(piece_mask(shadow_codes_q[k*CODE_W +: CODE_W]) & (8'h01 << (r*4 + c)));
            code_d = shadow_codes_q[k*CODE_W +: CODE_W];
            dx_d   = OFF_W'(px - 32'(X_ORIGIN + c*SIZE));
            dy_d   = OFF_W'(py - 32'(Y_ORIGIN + k*SLOT_PITCH + r*SIZE));
          end
        end
      end
    end
  end

  logic [10:0]       hcount1_q, vcount1_q;
  logic              hsync1_q, hblnk1_q, vsync1_q, vblnk1_q;
  logic [11:0]       rgb1_q;
  logic              occ1_q;
  logic [CODE_W-1:0] code1_q;
  logic [OFF_W-1:0]  dx1_q, dy1_q;

  // Stage 1 registers: delayed timing plus the resolved cell and in-cell offsets
  always_ff @(posedge pclk) begin
    if (!rst) begin
      hcount1_q <= '0;
      vcount1_q <= '0;
      hsync1_q  <= 1'b0;
      hblnk1_q  <= 1'b0;
      vsync1_q  <= 1'b0;
      vblnk1_q  <= 1'b0;
      rgb1_q    <= '0;
      occ1_q    <= 1'b0;
      code1_q   <= '0;
      dx1_q     <= '0;
      dy1_q     <= '0;
    end else begin
      hcount1_q <= hcount_in;
      vcount1_q <= vcount_in;
      hsync1_q  <= hsync_in;
      hblnk1_q  <= hblnk_in;
      vsync1_q  <= vsync_in;
      vblnk1_q  <= vblnk_in;
      rgb1_q    <= rgb_in;
      occ1_q    <= occ_d;
      code1_q   <= code_d;
      dx1_q     <= dx_d;
      dy1_q     <= dy_d;
    end
  end

  logic [31:0] dxe, dye;
  shade_e      shade;
  logic [11:0] rgb_d;

  // Stage 2 colour: dark bevel on the lower-right triangle wins over the light upper-left bevel
  always_comb begin
    dxe   = 32'(dx1_q);
    dye   = 32'(dy1_q);
    shade = SHADE_NORMAL;
    rgb_d = rgb1_q;
    if (((dxe >= 32'(SIZE - BEVEL)) || (dye >= 32'(SIZE - BEVEL))) && ((dxe + dye) >= 32'(SIZE - 1))) begin
      shade = SHADE_DARK;
    end else if ((dxe < 32'(BEVEL)) || (dye < 32'(BEVEL))) begin
      shade = SHADE_LIGHT;
    end
    if (hblnk1_q || vblnk1_q) begin
      rgb_d = '0;
    end else if (occ1_q) begin
      rgb_d = piece_colour(code1_q, shade);
    end
  end

  // Stage 2 registers drive the video outputs
  always_ff @(posedge pclk) begin
    if (!rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount1_q;
      vcount_out <= vcount1_q;
      hsync_out  <= hsync1_q;
      hblnk_out  <= hblnk1_q;
      vsync_out  <= vsync1_q;
      vblnk_out  <= vblnk1_q;
      rgb_out    <= rgb_d;
    end
  end

endmodule
